// File: rtl/ad_sync_word_detector_if.sv
// Word-stream bundle between the LVDS deserializer side and the sync word detector.
// The slave modport is the detector's view; master is the producer/consumer side.
interface ad_sync_word_detector_if;
    logic        i_word_valid;
    logic [15:0] iv_word;
    logic [15:0] iv_sync_word0;
    logic [15:0] iv_sync_word1;
    logic [15:0] iv_sync_word2;
    logic [15:0] iv_sync_word3;
    logic [15:0] iv_sync_word4;
    logic [15:0] iv_sync_word5;
    logic [15:0] iv_sync_word6;
    logic        o_sync_found;
    logic        o_locked;
    logic        o_sync_error;
    logic [12:0] ov_line_period;
    logic        o_data_valid;
    logic [15:0] ov_data;
    logic        o_line_start;
    logic [12:0] ov_hcount;

    modport slave (
        input  i_word_valid, iv_word,
        input  iv_sync_word0, iv_sync_word1, iv_sync_word2, iv_sync_word3,
        input  iv_sync_word4, iv_sync_word5, iv_sync_word6,
        output o_sync_found, o_locked, o_sync_error, ov_line_period,
        output o_data_valid, ov_data, o_line_start, ov_hcount
    );

    modport master (
        output i_word_valid, iv_word,
        output iv_sync_word0, iv_sync_word1, iv_sync_word2, iv_sync_word3,
        output iv_sync_word4, iv_sync_word5, iv_sync_word6,
        input  o_sync_found, o_locked, o_sync_error, ov_line_period,
        input  o_data_valid, ov_data, o_line_start, ov_hcount
    );
endinterface

// File: rtl/ad_sync_word_detector.sv
// Receive-side AD sync detector: finds the 7-word sync sequence, locks onto the line
// period with a flywheel, and delivers pixel words with sync stripped plus a line index.
module ad_sync_word_detector #(
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned UNLOCK_CNT = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    ad_sync_word_detector_if.slave        io_bus
);

    localparam logic [1:0]  ST_SEARCH  = 2'd0;
    localparam logic [1:0]  ST_VERIFY  = 2'd1;
    localparam logic [1:0]  ST_LOCKED  = 2'd2;
    localparam logic [3:0]  LOCK_LAST  = 4'(LOCK_CNT - 1);
    localparam logic [3:0]  UNLOCK_LIM = 4'(UNLOCK_CNT);
    localparam logic [12:0] CNT_MAX    = 13'h1FFF;
    localparam int          DL         = 7;

    function automatic logic [12:0] f_sat_inc(input logic [12:0] v);
        f_sat_inc = (v == CNT_MAX) ? CNT_MAX : v + 13'd1;
    endfunction

    // Matcher, line counter and lock FSM state
    logic [2:0]  r_m;
    logic [12:0] r_line_cnt;
    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [2:0]  r_miss;
    logic [12:0] r_period;
    logic        r_have_period;

    // Delay line and output-side state
    logic [15:0]   r_dl_word [DL];
    logic [DL-1:0] r_dl_vld;
    logic [DL-1:0] r_dl_tag;
    logic          r_after_tag;
    logic [12:0]   r_hc_next;

    logic          r_sync_found;
    logic          r_locked;
    logic          r_sync_error;
    logic [12:0]   r_line_period;
    logic          r_data_valid;
    logic [15:0]   r_data;
    logic          r_line_start;
    logic [12:0]   r_hcount;

    logic          w_valid;
    logic [15:0]   w_sync_exp;
    logic          w_hit;
    logic          w_is_sync0;
    logic          w_found;
    logic [2:0]    w_m_next;
    logic [12:0]   w_line_inc;
    logic          w_expected;
    logic [3:0]    w_cnt_inc;
    logic [3:0]    w_miss_inc;
    logic [1:0]    w_state_next;
    logic [2:0]    w_cnt_next;
    logic [2:0]    w_miss_next;
    logic [12:0]   w_period_next;
    logic          w_have_next;
    logic          w_err;
    logic          w_flywheel;
    logic          w_leave;
    logic          w_out_data;
    logic          w_out_tag;
    logic [12:0]   w_hc;
    logic [12:0]   w_hc_inc;

    assign w_valid    = io_bus.i_word_valid;
    assign w_hit      = (io_bus.iv_word == w_sync_exp);
    assign w_is_sync0 = (io_bus.iv_word == io_bus.iv_sync_word0);
    assign w_found    = w_valid && w_hit && (r_m == 3'd6);
    // The measured period and the saturating line-count increment are the same value
    assign w_line_inc = f_sat_inc(r_line_cnt);
    assign w_expected = w_valid && (r_state == ST_LOCKED) && (w_line_inc == r_period);
    assign w_cnt_inc  = {1'b0, r_cnt} + 4'd1;
    assign w_miss_inc = {1'b0, r_miss} + 4'd1;

    assign w_leave    = w_valid && r_dl_vld[DL-1];
    assign w_out_data = w_leave && !r_dl_tag[DL-1];
    assign w_out_tag  = w_leave && r_dl_tag[DL-1];
    assign w_hc       = r_after_tag ? 13'd0 : r_hc_next;
    assign w_hc_inc   = f_sat_inc(w_hc);

    // Select the sync word the matcher expects next
    always_comb begin
        w_sync_exp = io_bus.iv_sync_word0;
        case (r_m)
            3'd0:    w_sync_exp = io_bus.iv_sync_word0;
            3'd1:    w_sync_exp = io_bus.iv_sync_word1;
            3'd2:    w_sync_exp = io_bus.iv_sync_word2;
            3'd3:    w_sync_exp = io_bus.iv_sync_word3;
            3'd4:    w_sync_exp = io_bus.iv_sync_word4;
            3'd5:    w_sync_exp = io_bus.iv_sync_word5;
            3'd6:    w_sync_exp = io_bus.iv_sync_word6;
            default: w_sync_exp = io_bus.iv_sync_word0;
        endcase
    end

    // Matcher next index; a mismatch only retries against sync word 0
    always_comb begin
        w_m_next = r_m;
        if (!w_valid) begin
            w_m_next = r_m;
        end else if (w_hit) begin
            w_m_next = (r_m == 3'd6) ? 3'd0 : r_m + 3'd1;
        end else if (w_is_sync0) begin
            w_m_next = 3'd1;
        end else begin
            w_m_next = 3'd0;
        end
    end

    // Lock FSM next-state, period verification and flywheel error detection
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_miss_next   = r_miss;
        w_period_next = r_period;
        w_have_next   = r_have_period;
        w_err         = 1'b0;
        w_flywheel    = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_found) begin
                    w_state_next = ST_VERIFY;
                    w_cnt_next   = 3'd0;
                    w_have_next  = 1'b0;
                end else begin
                    w_state_next = ST_SEARCH;
                end
            end
            ST_VERIFY: begin
                if (!w_found) begin
                    w_state_next = ST_VERIFY;
                end else if (r_have_period && (w_line_inc == r_period)) begin
                    if (w_cnt_inc >= LOCK_LAST) begin
                        w_state_next = ST_LOCKED;
                        w_cnt_next   = 3'd0;
                        w_miss_next  = 3'd0;
                    end else begin
                        w_cnt_next   = w_cnt_inc[2:0];
                    end
                end else begin
                    w_period_next = w_line_inc;
                    w_have_next   = 1'b1;
                    w_cnt_next    = 3'd0;
                end
            end
            ST_LOCKED: begin
                // A sync that is missing at, or present away from, the expected beat counts as a miss
                if (w_valid && (w_expected != w_found)) begin
                    w_err      = 1'b1;
                    w_flywheel = w_expected;
                    if (w_miss_inc >= UNLOCK_LIM) begin
                        w_state_next = ST_SEARCH;
                        w_miss_next  = 3'd0;
                    end else begin
                        w_miss_next  = w_miss_inc[2:0];
                    end
                end else if (w_found) begin
                    w_miss_next = 3'd0;
                end else begin
                    w_state_next = ST_LOCKED;
                end
            end
            default: begin
                w_state_next = ST_SEARCH;
                w_cnt_next   = 3'd0;
                w_miss_next  = 3'd0;
            end
        endcase
    end

    // Matcher, line counter and lock FSM registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m           <= 3'd0;
            r_line_cnt    <= 13'd0;
            r_state       <= ST_SEARCH;
            r_cnt         <= 3'd0;
            r_miss        <= 3'd0;
            r_period      <= 13'd0;
            r_have_period <= 1'b0;
        end else if (w_valid) begin
            r_m           <= w_m_next;
            r_line_cnt    <= (w_found || w_flywheel) ? 13'd0 : w_line_inc;
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_miss        <= w_miss_next;
            r_period      <= w_period_next;
            r_have_period <= w_have_next;
        end
    end

    // Delay line: a completed match tags the six held words and the incoming one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DL; k++) begin
                r_dl_word[k] <= 16'd0;
            end
            r_dl_vld <= '0;
            r_dl_tag <= '0;
        end else if (w_valid) begin
            r_dl_word[0] <= io_bus.iv_word;
            for (int k = 1; k < DL; k++) begin
                r_dl_word[k] <= r_dl_word[k-1];
            end
            r_dl_vld <= {r_dl_vld[DL-2:0], 1'b1};
            r_dl_tag <= w_found ? {DL{1'b1}} : {r_dl_tag[DL-2:0], 1'b0};
        end
    end

    // Registered outputs: status pulses, measured period, pixel word and line index
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_found  <= 1'b0;
            r_locked      <= 1'b0;
            r_sync_error  <= 1'b0;
            r_line_period <= 13'd0;
            r_data_valid  <= 1'b0;
            r_data        <= 16'd0;
            r_line_start  <= 1'b0;
            r_hcount      <= 13'd0;
            r_after_tag   <= 1'b0;
            r_hc_next     <= 13'd0;
        end else begin
            r_sync_found <= w_found;
            r_sync_error <= w_err;
            r_locked     <= (w_state_next == ST_LOCKED);
            r_data_valid <= w_out_data;
            r_line_start <= w_out_data && r_after_tag;
            if (w_found) begin
                r_line_period <= w_line_inc;
            end
            if (w_leave) begin
                r_data <= r_dl_word[DL-1];
            end
            if (w_out_data) begin
                r_hcount    <= w_hc;
                r_hc_next   <= w_hc_inc;
                r_after_tag <= 1'b0;
            end else if (w_out_tag) begin
                r_after_tag <= 1'b1;
            end
        end
    end

    assign io_bus.o_sync_found   = r_sync_found;
    assign io_bus.o_locked       = r_locked;
    assign io_bus.o_sync_error   = r_sync_error;
    assign io_bus.ov_line_period = r_line_period;
    assign io_bus.o_data_valid   = r_data_valid;
    assign io_bus.ov_data        = r_data;
    assign io_bus.o_line_start   = r_line_start;
    assign io_bus.ov_hcount      = r_hcount;

endmodule

// File: tb/tb_ad_sync_word_detector.sv
// Directed bench for ad_sync_word_detector: scoreboard of expected pixel words plus
// lock/error/period checks across clean, corrupted, late, gapped and reset streams.
module tb_ad_sync_word_detector;

    typedef struct {
        logic [15:0] w;
        logic        ls;
        logic [12:0] hc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ad_sync_word_detector_if u_if ();

    ad_sync_word_detector #(.LOCK_CNT(3), .UNLOCK_CNT(2)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (u_if)
    );

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          sf_cnt   = 0;
    int          err_cnt  = 0;
    bit          gap      = 1'b0;
    bit          pending_ls = 1'b0;
    logic [12:0] hc_next  = 13'd0;
    logic [15:0] sync_w [7];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        exp_t e;
        if (u_if.o_sync_found === 1'b1) sf_cnt++;
        if (u_if.o_sync_error === 1'b1) err_cnt++;
        if (u_if.o_data_valid === 1'b1) begin
            check("word_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("data", 32'(u_if.ov_data), 32'(e.w));
                check("line_start", 32'(u_if.o_line_start), 32'(e.ls));
                check("hcount", 32'(u_if.ov_hcount), 32'(e.hc));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
        sample();
    endtask

    task automatic send_word(input logic [15:0] w);
        u_if.iv_word      = w;
        u_if.i_word_valid = 1'b1;
        tick();
        if (gap) begin
            u_if.i_word_valid = 1'b0;
            tick();
        end
    endtask

    task automatic send_data(input logic [15:0] w);
        exp_t e;
        e.w = w;
        if (pending_ls) begin
            e.hc = 13'd0;
            e.ls = 1'b1;
            pending_ls = 1'b0;
        end else begin
            e.hc = hc_next;
            e.ls = 1'b0;
        end
        hc_next = (e.hc == 13'h1FFF) ? e.hc : e.hc + 13'd1;
        q.push_back(e);
        send_word(w);
    endtask

    task automatic send_sync(input int cidx, output logic err_last);
        int c;
        err_last = 1'b0;
        for (int i = 0; i < 7; i++) begin
            logic [15:0] w;
            w = (i == cidx) ? 16'h1234 : sync_w[i];
            c = err_cnt;
            if (cidx >= 0) send_data(w);
            else           send_word(w);
            if (i == 6) err_last = (err_cnt != c);
        end
        if (cidx < 0) pending_ls = 1'b1;
    endtask

    task automatic send_line(input int nd, input int cidx, output logic err_last);
        repeat (nd) send_data(16'($urandom_range(0, 16'hDFFF)));
        send_sync(cidx, err_last);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic el;
        int   e0;
        int   s0;
        sync_w[0] = 16'hFA00; sync_w[1] = 16'hF511; sync_w[2] = 16'hF0C2; sync_w[3] = 16'hFF33;
        sync_w[4] = 16'hE844; sync_w[5] = 16'hF755; sync_w[6] = 16'hFB66;
        u_if.iv_sync_word0 = sync_w[0]; u_if.iv_sync_word1 = sync_w[1];
        u_if.iv_sync_word2 = sync_w[2]; u_if.iv_sync_word3 = sync_w[3];
        u_if.iv_sync_word4 = sync_w[4]; u_if.iv_sync_word5 = sync_w[5];
        u_if.iv_sync_word6 = sync_w[6];
        u_if.i_word_valid = 1'b0;
        u_if.iv_word      = 16'd0;
        reset_n           = 1'b0;

        // Reset held with valid random words: everything stays at zero
        repeat (8) send_word(16'($urandom_range(0, 65535)));
        check("rst_sync_found", 32'(u_if.o_sync_found), 32'd0);
        check("rst_locked", 32'(u_if.o_locked), 32'd0);
        check("rst_sync_error", 32'(u_if.o_sync_error), 32'd0);
        check("rst_line_period", 32'(u_if.ov_line_period), 32'd0);
        check("rst_data_valid", 32'(u_if.o_data_valid), 32'd0);
        check("rst_data", 32'(u_if.ov_data), 32'd0);
        check("rst_line_start", 32'(u_if.o_line_start), 32'd0);
        check("rst_hcount", 32'(u_if.ov_hcount), 32'd0);
        u_if.i_word_valid = 1'b0;
        reset_n = 1'b1;
        tick();

        // Partial sync, restart on sync0, then a full sync found on its 7th word
        send_data(sync_w[0]); send_data(sync_w[1]); send_data(sync_w[2]); send_data(sync_w[3]);
        send_data(16'h1234);
        send_data(sync_w[0]); send_data(sync_w[1]);
        for (int i = 0; i < 7; i++) begin
            send_word(sync_w[i]);
            check("sync_found_beat", 32'(u_if.o_sync_found), (i == 6) ? 32'd1 : 32'd0);
        end
        pending_ls = 1'b1;
        check("first_period", 32'(u_if.ov_line_period), 32'd14);
        check("sf_count_1", 32'(sf_cnt), 32'd1);
        check("search_unlocked", 32'(u_if.o_locked), 32'd0);

        // Clean period-100 lines: lock on the 4th sync_found
        for (int l = 1; l <= 3; l++) begin
            send_line(93, -1, el);
            check("period_100", 32'(u_if.ov_line_period), 32'd100);
            check("lock_progress", 32'(u_if.o_locked), (l == 3) ? 32'd1 : 32'd0);
        end
        check("sf_count_4", 32'(sf_cnt), 32'd4);
        check("no_err_clean", 32'(err_cnt), 32'd0);

        // Single corrupted sync keeps lock; two in a row drop it
        e0 = err_cnt;
        send_line(93, 4, el);
        check("err_at_expected_beat", 32'(el), 32'd1);
        check("err_count_1", 32'(err_cnt - e0), 32'd1);
        check("lock_kept", 32'(u_if.o_locked), 32'd1);
        send_line(93, -1, el);
        check("lock_recovered_line", 32'(u_if.o_locked), 32'd1);
        check("err_count_still_1", 32'(err_cnt - e0), 32'd1);
        send_line(93, 4, el);
        check("lock_after_miss1", 32'(u_if.o_locked), 32'd1);
        send_line(93, 4, el);
        check("unlock_after_miss2", 32'(u_if.o_locked), 32'd0);
        check("err_count_3", 32'(err_cnt - e0), 32'd3);

        // Relock, then a 101-word line: miss at expected beat plus misplaced sync
        s0 = sf_cnt;
        for (int l = 1; l <= 4; l++) begin
            send_line(93, -1, el);
            check("relock_progress", 32'(u_if.o_locked), (l == 4) ? 32'd1 : 32'd0);
        end
        check("relock_sf_count", 32'(sf_cnt - s0), 32'd4);
        e0 = err_cnt;
        send_line(94, -1, el);
        check("late_sync_err", 32'(el), 32'd1);
        check("late_err_count", 32'(err_cnt - e0), 32'd2);
        check("late_unlock", 32'(u_if.o_locked), 32'd0);
        check("late_period", 32'(u_if.ov_line_period), 32'd1);

        // Gapped valid with a reset pulse mid-line, then relock from scratch
        gap = 1'b1;
        send_line(93, -1, el);
        send_line(93, -1, el);
        repeat (40) send_data(16'($urandom_range(0, 16'hDFFF)));
        reset_n = 1'b0;
        #1;
        check("midrst_data_valid", 32'(u_if.o_data_valid), 32'd0);
        check("midrst_hcount", 32'(u_if.ov_hcount), 32'd0);
        check("midrst_period", 32'(u_if.ov_line_period), 32'd0);
        u_if.i_word_valid = 1'b0;
        q.delete();
        pending_ls = 1'b0;
        hc_next    = 13'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        s0 = sf_cnt;
        send_line(50, -1, el);
        for (int l = 2; l <= 4; l++) begin
            send_line(93, -1, el);
            check("gap_period", 32'(u_if.ov_line_period), 32'd100);
            check("gap_lock_progress", 32'(u_if.o_locked), (l == 4) ? 32'd1 : 32'd0);
        end
        check("gap_sf_count", 32'(sf_cnt - s0), 32'd4);
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
